// File: rtl/fetch_stage.sv
// fetch_stage: PC register, word-addressed instruction memory and IF/ID pipeline register
module fetch_stage #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP        = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [31:0]                   load_data,
  output logic [31:0]                   pc,
  output logic [31:0]                   if_id_instr,
  output logic [31:0]                   if_id_pc,
  output logic [31:0]                   if_id_pc_plus4,
  output logic                          if_id_valid,
  output logic [31:0]                   fetch_count
);
  localparam int AW = $clog2(IMEM_DEPTH);
  logic [31:0] mem [IMEM_DEPTH];
  logic [31:0] fetched;
  logic [31:0] pc_next;
  // Word index is in range only when every PC bit above the index field is zero
  always_comb begin
    fetched = ~|pc[31:AW+2] ? mem[pc[AW+1:2]] : NOP;
    pc_next = pc + 32'd4;
  end
  // Boot/test load port; the memory is never reset so loads during reset still land
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end
  // PC and IF/ID update with priority reset > redirect > stall > normal
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      if_id_instr    <= NOP;
      if_id_pc       <= 32'd0;
      if_id_pc_plus4 <= 32'd4;
      if_id_valid    <= 1'b0;
      fetch_count    <= 32'd0;
    end else if (redirect_valid) begin
      pc          <= {redirect_pc[31:2], 2'b00};
      if_id_instr <= NOP;
      if_id_valid <= 1'b0;
    end else if (stall) begin
      if (flush) begin
        if_id_instr <= NOP;
        if_id_valid <= 1'b0;
      end
    end else begin
      pc <= pc_next;
      if (flush) begin
        if_id_instr <= NOP;
        if_id_valid <= 1'b0;
      end else begin
        if_id_instr    <= fetched;
        if_id_pc       <= pc;
        if_id_pc_plus4 <= pc_next;
        if_id_valid    <= 1'b1;
        fetch_count    <= fetch_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
  localparam logic [31:0] NOPW = 32'hF0F0_0000;
  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect_valid, load_en;
  logic [31:0] redirect_pc, load_data;
  logic [5:0]  load_addr;
  logic [31:0] pc, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count;
  logic        if_id_valid;
  int          vectors = 0;
  int          errs = 0;

  fetch_stage #(.IMEM_DEPTH(64), .RESET_PC(32'h0), .NOP(NOPW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                         input logic [31:0] e_ipc, input logic [31:0] e_p4,
                         input logic e_valid, input logic [31:0] e_cnt);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".instr"}, if_id_instr, e_instr);
    chk({tag, ".if_id_pc"}, if_id_pc, e_ipc);
    chk({tag, ".pc_plus4"}, if_id_pc_plus4, e_p4);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
    chk({tag, ".count"}, fetch_count, e_cnt);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; load_en = 1'b0; load_addr = 6'd0; load_data = 32'h0;
    for (int i = 0; i < 8; i++) begin
      load_en = 1'b1; load_addr = 6'(i); load_data = 32'h11 * 32'(i + 1);
      tick();
    end
    load_en = 1'b0;
    chk_all("reset", 32'h0, NOPW, 32'h0, 32'h4, 1'b0, 32'd0);
    reset = 1'b0;
    tick();
    chk_all("edge1", 32'h4, 32'h11, 32'h0, 32'h4, 1'b1, 32'd1);
    tick(); tick(); tick();
    chk_all("edge4", 32'h10, 32'h44, 32'hC, 32'h10, 1'b1, 32'd4);
    redirect_valid = 1'b1; redirect_pc = 32'h4;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk_all("pre_stall", 32'h8, 32'h22, 32'h4, 32'h8, 1'b1, 32'd5);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("stall", 32'h8, 32'h22, 32'h4, 32'h8, 1'b1, 32'd5);
    end
    stall = 1'b0;
    tick();
    chk_all("unstall", 32'hC, 32'h33, 32'h8, 32'hC, 1'b1, 32'd6);
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_000B;
    tick();
    chk_all("redir", 32'h8, NOPW, 32'h8, 32'hC, 1'b0, 32'd6);
    stall = 1'b0; redirect_valid = 1'b0;
    tick();
    chk_all("redir_tgt", 32'hC, 32'h33, 32'h8, 32'hC, 1'b1, 32'd7);
    flush = 1'b1;
    tick();
    chk_all("flush", 32'h10, NOPW, 32'h8, 32'hC, 1'b0, 32'd7);
    flush = 1'b0;
    tick();
    chk_all("after_flush", 32'h14, 32'h55, 32'h10, 32'h14, 1'b1, 32'd8);
    flush = 1'b1; stall = 1'b1;
    tick();
    chk_all("flush_stall", 32'h14, NOPW, 32'h10, 32'h14, 1'b0, 32'd8);
    flush = 1'b0; stall = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("oor_redir.pc", pc, 32'h100);
    tick();
    chk_all("oor", 32'h104, NOPW, 32'h100, 32'h104, 1'b1, 32'd9);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_redir.pc", pc, 32'hFFFF_FFFC);
    tick();
    chk_all("wrap", 32'h0, NOPW, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd10);
    load_en = 1'b1; load_addr = 6'd0; load_data = 32'hAA;
    tick();
    load_en = 1'b0;
    chk_all("collide", 32'h4, 32'h11, 32'h0, 32'h4, 1'b1, 32'd11);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk_all("refetch", 32'h4, 32'hAA, 32'h0, 32'h4, 1'b1, 32'd12);
    stall = 1'b1;
    tick();
    chk_all("pre_reset_stall", 32'h4, 32'hAA, 32'h0, 32'h4, 1'b1, 32'd12);
    reset = 1'b1;
    tick();
    chk_all("mid_reset", 32'h0, NOPW, 32'h0, 32'h4, 1'b0, 32'd0);
    reset = 1'b0; stall = 1'b0;
    tick();
    chk_all("retained0", 32'h4, 32'hAA, 32'h0, 32'h4, 1'b1, 32'd1);
    tick();
    chk_all("retained1", 32'h8, 32'h22, 32'h4, 32'h8, 1'b1, 32'd2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
